// File: rtl/alu_issue_stage_pkg.sv
// Shared types for the ALU issue/result pipeline: bus and opcode types,
// stage payload structs and the opcode legality helper.
package alu_issue_stage_pkg;

  localparam int BUS_W     = 32;
  localparam int ALU_TAG_W = 5;

  typedef logic [BUS_W-1:0] bus_type;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_oper_type;

  typedef struct packed {
    bus_type                a;
    bus_type                b;
    alu_oper_type           sel;
    logic [ALU_TAG_W-1:0]   tag;
  } alu_issue_t;

  typedef struct packed {
    bus_type                s;
    logic                   zero;
    logic                   illegal;
    logic [ALU_TAG_W-1:0]   tag;
  } alu_result_t;

  function automatic logic is_legal_alu_op(alu_oper_type op);
    case (op)
      ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SUB,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream issue handshake, ALU operand/result wires and downstream result
// handshake of the ALU issue stage.
interface alu_issue_stage_if
  import alu_issue_stage_pkg::*;
#(
  parameter int TAG_W = ALU_TAG_W
) ();

  logic               in_valid;
  logic               in_ready;
  bus_type            in_a;
  bus_type            in_b;
  alu_oper_type       in_sel;
  logic [TAG_W-1:0]   in_tag;
  logic               in_fwd_a;
  logic               in_fwd_b;

  bus_type            alu_a;
  bus_type            alu_b;
  alu_oper_type       alu_sel;
  bus_type            alu_s;

  logic               out_valid;
  logic               out_ready;
  bus_type            out_s;
  logic               out_zero;
  logic [TAG_W-1:0]   out_tag;
  logic               out_illegal;

  modport master (
    output in_valid, in_a, in_b, in_sel, in_tag, in_fwd_a, in_fwd_b,
    output alu_s, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel,
    input  out_valid, out_s, out_zero, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, in_tag, in_fwd_a, in_fwd_b,
    input  alu_s, out_ready,
    output in_ready, alu_a, alu_b, alu_sel,
    output out_valid, out_s, out_zero, out_tag, out_illegal
  );

endinterface

// File: rtl/alu_issue_stage_pipe_reg.sv
// Generic one-entry valid/ready register slice; payload only moves on a
// transfer so it holds stable under backpressure.
module alu_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage execute pipeline around an external combinational ALU: issue
// register with operand forwarding, result register with zero/illegal flags.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int TAG_W = ALU_TAG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_stage_if.slave bus,
  output logic [CNT_W-1:0] op_count
);

  alu_issue_t       s1_d, s1_q;
  alu_result_t      s2_d, s2_q;
  logic             s1_valid, s1_in_ready;
  logic             s2_valid, s2_in_ready;
  logic             s1_advance, retire;
  bus_type          fwd_val;
  bus_type          last_result_d, last_result_q;
  logic [CNT_W-1:0] op_count_d, op_count_q;

  assign s1_advance = s1_valid && s2_in_ready;
  assign retire     = s2_valid && bus.out_ready;

  // Result capture: illegal opcodes are squashed to zero before the flag compare.
  always_comb begin
    s2_d         = '0;
    s2_d.illegal = !is_legal_alu_op(s1_q.sel);
    s2_d.s       = s2_d.illegal ? '0 : bus.alu_s;
    s2_d.zero    = (s2_d.s == '0);
    s2_d.tag     = s1_q.tag;
  end

  // Forward the youngest older result; the producer in stage 1 forwards its
  // squashed value so a consumer sees exactly what that producer will retire.
  always_comb begin
    if (s1_advance)    fwd_val = s2_d.s;
    else if (s2_valid) fwd_val = s2_q.s;
    else               fwd_val = last_result_q;
  end

  always_comb begin
    s1_d     = '0;
    s1_d.a   = bus.in_fwd_a ? fwd_val : bus.in_a;
    s1_d.b   = bus.in_fwd_b ? fwd_val : bus.in_b;
    s1_d.sel = bus.in_sel;
    s1_d.tag = bus.in_tag;
  end

  always_comb begin
    last_result_d = last_result_q;
    op_count_d    = op_count_q;
    if (retire) begin
      last_result_d = s2_q.s;
      if (op_count_q != '1) op_count_d = op_count_q + CNT_W'(1);
    end
  end

  alu_pipe_reg #(.W($bits(alu_issue_t))) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (s1_in_ready),
    .in_data   (s1_d),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_q)
  );

  alu_pipe_reg #(.W($bits(alu_result_t))) u_stage2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_d),
    .out_valid (s2_valid),
    .out_ready (bus.out_ready),
    .out_data  (s2_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_result_q <= '0;
      op_count_q    <= '0;
    end else begin
      last_result_q <= last_result_d;
      op_count_q    <= op_count_d;
    end
  end

  assign bus.in_ready    = s1_in_ready;
  assign bus.alu_a       = s1_q.a;
  assign bus.alu_b       = s1_q.b;
  assign bus.alu_sel     = s1_q.sel;
  assign bus.out_valid   = s2_valid;
  assign bus.out_s       = s2_q.s;
  assign bus.out_zero    = s2_q.zero;
  assign bus.out_tag     = s2_q.tag;
  assign bus.out_illegal = s2_q.illegal;
  assign op_count        = op_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU stub, program-order result queue
// as reference, directed scenarios followed by randomized traffic.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  localparam int TAG_W   = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic [CNT_W-1:0] op_count;

  alu_issue_stage_if #(.TAG_W(TAG_W)) bus ();

  alu_issue_stage #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  function automatic bus_type alu_ref(bus_type a, bus_type b, logic [3:0] sel);
    case (sel)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a ^ b;
      4'd3:    return a + b;
      4'd4:    return a - b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return bus_type'($signed(a) >>> b[4:0]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus.alu_s = alu_ref(bus.alu_a, bus.alu_b, bus.alu_sel);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: every accepted op, in program order, with its final result.
  typedef struct {
    bus_type          res;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t             q[$];
  exp_t             e;
  bus_type          prev_res = '0;
  int               exp_cnt  = 0;
  logic             hold_v   = 1'b0;
  bus_type          hold_s;
  logic [TAG_W-1:0] hold_tag;
  logic             hold_ill;
  bus_type          ma, mb;
  logic [3:0]       msel;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("op_count", op_count, exp_cnt);
        if (hold_v) begin
          check("stall_valid", bus.out_valid, 1'b1);
          check("stall_s", bus.out_s, hold_s);
          check("stall_tag", bus.out_tag, hold_tag);
          check("stall_ill", bus.out_illegal, hold_ill);
        end
        hold_v   = bus.out_valid && !bus.out_ready;
        hold_s   = bus.out_s;
        hold_tag = bus.out_tag;
        hold_ill = bus.out_illegal;
        if (bus.in_valid && bus.in_ready) begin
          ma    = bus.in_fwd_a ? prev_res : bus.in_a;
          mb    = bus.in_fwd_b ? prev_res : bus.in_b;
          msel  = bus.in_sel;
          e.ill = (msel > 4'd9);
          e.res = e.ill ? '0 : alu_ref(ma, mb, msel);
          e.tag = bus.in_tag;
          q.push_back(e);
          prev_res = e.res;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            check("spurious_retire", 1, 0);
          end else begin
            e = q.pop_front();
            check("ret_s", bus.out_s, e.res);
            check("ret_tag", bus.out_tag, e.tag);
            check("ret_ill", bus.out_illegal, e.ill);
            check("ret_zero", bus.out_zero, e.res == '0);
          end
          if (exp_cnt < CNT_MAX) exp_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] sel, input bus_type a, input bus_type b,
                        input logic [TAG_W-1:0] tag, input logic fa, input logic fb);
    bus.in_valid = 1'b1;
    bus.in_sel   = alu_oper_type'(sel);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    bus.in_fwd_a = fa;
    bus.in_fwd_b = fb;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_fwd_a = 1'b0;
    bus.in_fwd_b = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    q.delete();
    prev_res = '0;
    exp_cnt  = 0;
    hold_v   = 1'b0;
  endtask

  logic acc;
  int   wait_n;

  initial begin
    idle();
    bus.in_a = '0; bus.in_b = '0; bus.in_sel = ALU_AND; bus.in_tag = '0;
    bus.out_ready = 1'b0;
    #1 do_reset();
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_op_count", op_count, 0);
    check("rst_alu_sel", bus.alu_sel, ALU_AND);
    check("rst_out_s", bus.out_s, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    bus.out_ready = 1'b1;

    // Basic latency
    set_op(4'd3, 32'd3, 32'd4, 5'd1, 1'b0, 1'b0);
    cyc(); idle();
    check("lat_early_valid", bus.out_valid, 1'b0);
    cyc();
    check("lat_valid", bus.out_valid, 1'b1);
    check("lat_s", bus.out_s, 32'd7);
    check("lat_zero", bus.out_zero, 1'b0);
    check("lat_tag", bus.out_tag, 5'd1);
    cyc();
    check("lat_count", op_count, 1);

    // Zero flag
    set_op(4'd4, 32'd5, 32'd5, 5'd2, 1'b0, 1'b0);
    cyc(); idle(); cyc();
    check("zero_s", bus.out_s, 32'd0);
    check("zero_flag", bus.out_zero, 1'b1);
    cyc();

    // Back-to-back forwarding
    set_op(4'd3, 32'd1, 32'd2, 5'd3, 1'b0, 1'b0);
    cyc();
    set_op(4'd3, 32'd99, 32'd10, 5'd4, 1'b1, 1'b0);
    cyc(); idle();
    check("fwd_first", bus.out_s, 32'd3);
    cyc();
    check("fwd_b2b", bus.out_s, 32'd13);
    check("fwd_b2b_tag", bus.out_tag, 5'd4);
    cyc();

    // Forwarding after a gap
    set_op(4'd3, 32'd1, 32'd2, 5'd5, 1'b0, 1'b0);
    cyc(); idle();
    repeat (3) cyc();
    set_op(4'd3, 32'd77, 32'd10, 5'd6, 1'b1, 1'b0);
    cyc(); idle(); cyc();
    check("fwd_gap", bus.out_s, 32'd13);
    cyc();

    // Illegal opcode then a legal one
    set_op(4'hC, 32'd7, 32'd9, 5'd7, 1'b0, 1'b0);
    cyc(); idle(); cyc();
    check("ill_flag", bus.out_illegal, 1'b1);
    check("ill_s", bus.out_s, 32'd0);
    check("ill_zero", bus.out_zero, 1'b1);
    cyc();
    check("ill_count", op_count, 7);
    set_op(4'd1, 32'd1, 32'd2, 5'd8, 1'b0, 1'b0);
    cyc(); idle(); cyc();
    check("ill_clear", bus.out_illegal, 1'b0);
    check("ill_clear_s", bus.out_s, 32'd3);
    cyc();
    check("ill_count2", op_count, 8);

    // Reset with two ops in flight
    set_op(4'd3, 32'd1, 32'd1, 5'd9, 1'b0, 1'b0);
    cyc();
    set_op(4'd3, 32'd2, 32'd2, 5'd10, 1'b0, 1'b0);
    cyc();
    do_reset();
    #1;
    check("mid_rst_valid", bus.out_valid, 1'b0);
    check("mid_rst_ready", bus.in_ready, 1'b1);
    check("mid_rst_count", op_count, 0);
    check("mid_rst_sel", bus.alu_sel, ALU_AND);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) cyc();
    check("post_rst_valid", bus.out_valid, 1'b0);
    check("post_rst_count", op_count, 0);

    // Backpressure
    bus.out_ready = 1'b0;
    set_op(4'd3, 32'd10, 32'd1, 5'd11, 1'b0, 1'b0);
    cyc();
    check("bp_ready1", bus.in_ready, 1'b1);
    set_op(4'd3, 32'd20, 32'd2, 5'd12, 1'b0, 1'b0);
    cyc();
    check("bp_ready2", bus.in_ready, 1'b0);
    set_op(4'd3, 32'd30, 32'd3, 5'd13, 1'b0, 1'b0);
    repeat (3) begin
      cyc();
      check("bp_hold_valid", bus.out_valid, 1'b1);
      check("bp_hold_s", bus.out_s, 32'd11);
      check("bp_hold_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    cyc();
    check("bp_r1", bus.out_s, 32'd22);
    set_op(4'd3, 32'd40, 32'd4, 5'd14, 1'b0, 1'b0);
    cyc(); idle();
    check("bp_r2", bus.out_s, 32'd33);
    cyc();
    check("bp_r3", bus.out_s, 32'd44);
    cyc();
    check("bp_done_valid", bus.out_valid, 1'b0);
    check("bp_count", op_count, 4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc || !bus.in_valid) begin
        if ($urandom_range(3) != 0)
          set_op(4'($urandom_range(15)),
                 ($urandom_range(1) != 0) ? bus_type'($urandom_range(7)) : bus_type'($urandom),
                 ($urandom_range(1) != 0) ? bus_type'($urandom_range(7)) : bus_type'($urandom),
                 5'($urandom_range(31)),
                 ($urandom_range(3) == 0), ($urandom_range(3) == 0));
        else
          idle();
      end
      bus.out_ready = ($urandom_range(3) != 0);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    idle();
    bus.out_ready = 1'b1;
    wait_n = 0;
    while (q.size() != 0 && wait_n < 20) begin
      cyc();
      wait_n++;
    end
    cyc();
    check("drain_empty", q.size(), 0);
    check("drain_valid", bus.out_valid, 1'b0);
    check("sat_count", op_count, CNT_MAX);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Two-stage execute pipeline wrapped around the arithmetic unit's combinational datapath.
- Stage 1 (issue register) accepts an operation over a valid/ready handshake and drives the ALU's a/b/sel inputs from registers.
- Stage 2 (result register) captures the ALU result, derives a 1-bit zero flag and flags illegal opcodes.
- Stage 2 presents the result downstream over a valid/ready handshake and supports back-to-back result forwarding into operand A/B.

Parameters:
- TAG_W, 5, width of the destination-register tag carried alongside each operation.
- CNT_W, 16, width of the retired-operation counter (saturating).

Ports:
- clk  input  1  system clock, all flops rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream operation valid.
- in_ready  output  1  stage 1 can accept an operation this cycle.
- in_a  input  bus_type  operand A.
- in_b  input  bus_type  operand B.
- in_sel  input  alu_oper_type  ALU operation.
- in_tag  input  TAG_W  destination tag.
- in_fwd_a  input  1  replace operand A with the most recent stage-2 result.
- in_fwd_b  input  1  replace operand B with the most recent stage-2 result.
- alu_a  output  bus_type  to the arithmetic unit, operand A (registered).
- alu_b  output  bus_type  to the arithmetic unit, operand B (registered).
- alu_sel  output  alu_oper_type  to the arithmetic unit, operation (registered).
- alu_s  input  bus_type  arithmetic unit result (combinational from alu_a/alu_b/alu_sel).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_s  output  bus_type  registered result.
- out_zero  output  1  out_s == 0.
- out_tag  output  TAG_W  tag of the result.
- out_illegal  output  1  sel was not a defined alu_oper_type value; out_s forced to 0.
- op_count  output  CNT_W  number of results retired (out_valid && out_ready), saturating at all-ones.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both stage valid bits clear.
  - alu_a, alu_b, out_s, out_tag and last_result clear to 0; alu_sel resets to ALU_AND.
  - out_zero, out_illegal and op_count clear to 0.
  - Reset asserted mid-operation discards all in-flight operations with no partial retire.
- Handshake:
  - A transfer occurs when valid && ready are both high on a rising edge.
  - in_ready = !s1_valid || s1_advance, where s1_advance = s1_valid && (!s2_valid || out_ready).
  - Stage 2 loads whenever s1_advance; it goes empty when out_ready is high and s1_advance is low.
  - Full throughput is 1 op/cycle with out_ready held high.
  - Latency: in-accept edge to out_valid is 2 cycles.
  - Under stall (out_ready low), both stages hold every register stable; out_* must not change while out_valid && !out_ready.
- Forwarding:
  - last_result is updated with the stage-2 value on each retire.
  - in_fwd_a/in_fwd_b select a source at stage-1 load, in this priority order:
    1. The stage-1 ALU output alu_s, if s1_advance happens in the same cycle (producer is one ahead).
    2. Otherwise out_s, if s2_valid.
    3. Otherwise last_result.
  - Forwarding with no prior result since reset yields 0.
- Illegal sel:
  - Any encoding outside the defined alu_oper_type values sets out_illegal=1 and out_s=0, so out_zero=1.
  - The operation still retires and counts.
- Zero flag: computed in this block as a full-width compare of the captured result; the arithmetic unit's zero output is not used.
- SLT/SLTU: result taken from alu_s unchanged.
- op_count increments by 1 per retire and holds at 2^CNT_W-1.
- Simultaneous accept and retire in the same cycle is legal and keeps throughput; no bubble is inserted.

Decomposition:
- types package additions:
  - alu_issue_t struct {bus_type a; bus_type b; alu_oper_type sel; logic [TAG_W-1:0] tag;}.
  - function is_legal_alu_op(alu_oper_type).
- One sub-module, alu_pipe_reg: a generic valid/ready register slice, instantiated twice (stage 1 and stage 2), payload width parameterized.
- Forwarding mux, zero/illegal logic and the counter stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 ops in flight -> out_valid=0, in_ready=1, op_count=0, alu_sel=ALU_AND immediately, no retire after release.
- Basic latency: accept ADD a=3 b=4 tag=1, out_ready=1 -> out_valid exactly 2 cycles later, out_s=7, out_zero=0, out_tag=1, op_count=1.
- Zero flag: SUB a=5 b=5 -> out_s=0, out_zero=1.
- Back-to-back forwarding:
  - ADD 1+2, then an op with in_fwd_a=1, b=10, sel=ADD on the next cycle -> second result 13.
  - Repeat with a 3-cycle gap -> still 13 (last_result path).
- Backpressure: stream 4 ops while out_ready=0 -> in_ready drops after 2 accepts and out_* stay stable; release -> 4 results in order, one per cycle, op_count=4.
- Illegal op: drive undefined sel encoding -> out_illegal=1, out_s=0, out_zero=1, op_count increments; a following legal op clears out_illegal.
